// File: rtl/scene_ctrl.sv
// scene_ctrl: owns the game scene register. Scene changes requested by taps or
// game results are held pending and committed on the next frame_tick so that
// renderers never switch mid-frame. End screens ignore taps for a number of
// frames. A twinkle bit blinks the prompt text on START/WIN/LOSE.
//
// state   | meaning
// --------+-----------------------------------------------
// S_START | title screen, tap -> MENU
// S_MENU  | level select, tap with level_sel 1..3 -> PLAYn
// S_PLAY1 | level 1 running, game_win/game_lose -> WIN/LOSE
// S_PLAY2 | level 2 running
// S_PLAY3 | level 3 running
// S_WIN   | win screen, tap after lockout -> MENU
// S_LOSE  | lose screen, tap after lockout -> MENU
module scene_ctrl #(
    parameter int TWINKLE_FRAMES = 30,
    parameter int LOCKOUT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       tap,
    input  logic [1:0] level_sel,
    input  logic       game_win,
    input  logic       game_lose,
    output logic [2:0] scene,
    output logic       scene_change,
    output logic       twinkle,
    output logic       input_ready
);

    localparam int LW  = (LOCKOUT_FRAMES > 0) ? $clog2(LOCKOUT_FRAMES + 1) : 1;
    localparam int TWW = (TWINKLE_FRAMES > 1) ? $clog2(TWINKLE_FRAMES) : 1;
    localparam logic [LW-1:0]  LOCK_INIT = LW'(LOCKOUT_FRAMES);
    localparam logic [TWW-1:0] TW_LAST   = TWW'(TWINKLE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_MENU  = 3'd1,
        S_PLAY1 = 3'd2,
        S_PLAY2 = 3'd3,
        S_PLAY3 = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } scene_t;

    scene_t         scene_q;
    scene_t         pend_scene;
    logic           pend;
    logic [LW-1:0]  lock_cnt;
    logic [TWW-1:0] tw_cnt;

    scene_t         req_scene;
    logic           req_vld;
    scene_t         tgt_scene;
    logic           tgt_vld;
    logic           tgt_blink;
    logic           cur_blink;
    logic           scene_bad;
    logic [2:0]     scene_raw;

    assign scene_raw = scene_q;
    assign scene_bad = (scene_raw == 3'd7);
    assign cur_blink = (scene_q == S_START) || (scene_q == S_WIN) || (scene_q == S_LOSE);

    // New request from the registered scene; ignored while one is already pending
    always_comb begin
        req_vld   = 1'b0;
        req_scene = S_START;
        if (!pend) begin
            case (scene_q)
                S_START: begin
                    if (tap) begin
                        req_vld   = 1'b1;
                        req_scene = S_MENU;
                    end
                end
                S_MENU: begin
                    if (tap && (level_sel != 2'd0)) begin
                        req_vld   = 1'b1;
                        req_scene = scene_t'({1'b0, level_sel} + 3'd1);
                    end
                end
                S_PLAY1, S_PLAY2, S_PLAY3: begin
                    if (game_lose) begin
                        req_vld   = 1'b1;
                        req_scene = S_LOSE;
                    end else if (game_win) begin
                        req_vld   = 1'b1;
                        req_scene = S_WIN;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (tap && (lock_cnt == '0)) begin
                        req_vld   = 1'b1;
                        req_scene = S_MENU;
                    end
                end
                default: ;
            endcase
        end
    end

    // A pending request takes precedence; otherwise a same-cycle request commits directly
    always_comb begin
        tgt_vld   = pend | req_vld;
        tgt_scene = pend ? pend_scene : req_scene;
        tgt_blink = (tgt_scene == S_START) || (tgt_scene == S_WIN) || (tgt_scene == S_LOSE);
    end

    // Scene register, pending request, lockout counter and twinkle blink
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scene_q      <= S_START;
            pend         <= 1'b0;
            pend_scene   <= S_START;
            scene_change <= 1'b0;
            lock_cnt     <= '0;
            tw_cnt       <= '0;
            twinkle      <= 1'b1;
        end else begin
            scene_change <= 1'b0;
            if (frame_tick && scene_bad) begin
                scene_q      <= S_START;
                scene_change <= 1'b1;
                pend         <= 1'b0;
                lock_cnt     <= '0;
                tw_cnt       <= '0;
                twinkle      <= 1'b1;
            end else if (frame_tick && tgt_vld) begin
                scene_q      <= tgt_scene;
                scene_change <= 1'b1;
                pend         <= 1'b0;
                lock_cnt     <= ((tgt_scene == S_WIN) || (tgt_scene == S_LOSE)) ? LOCK_INIT : '0;
                tw_cnt       <= '0;
                twinkle      <= tgt_blink;
            end else begin
                if (req_vld) begin
                    pend       <= 1'b1;
                    pend_scene <= req_scene;
                end
                if (frame_tick) begin
                    if (lock_cnt != '0)
                        lock_cnt <= lock_cnt - LW'(1);
                    if (cur_blink) begin
                        if (tw_cnt == TW_LAST) begin
                            tw_cnt  <= '0;
                            twinkle <= ~twinkle;
                        end else begin
                            tw_cnt <= tw_cnt + TWW'(1);
                        end
                    end
                end
            end
        end
    end

    assign scene       = scene_q;
    assign input_ready = !pend &&
                         ((scene_q == S_START) ||
                          ((scene_q == S_MENU) && (level_sel != 2'd0)) ||
                          (((scene_q == S_WIN) || (scene_q == S_LOSE)) && (lock_cnt == '0)));

endmodule

// File: tb/tb_scene_ctrl.sv
// Testbench for scene_ctrl: directed table, hand sequences for lockout/twinkle
// and reset-with-pending, then random stimulus against a frame-count model.
module tb_scene_ctrl;

    localparam int TW   = 30;
    localparam int LOCK = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       tap;
    logic [1:0] level_sel;
    logic       game_win;
    logic       game_lose;
    logic [2:0] scene;
    logic       scene_change;
    logic       twinkle;
    logic       input_ready;

    int n_vec = 0;
    int n_err = 0;

    scene_ctrl #(.TWINKLE_FRAMES(TW), .LOCKOUT_FRAMES(LOCK)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .tap          (tap),
        .level_sel    (level_sel),
        .game_win     (game_win),
        .game_lose    (game_lose),
        .scene        (scene),
        .scene_change (scene_change),
        .twinkle      (twinkle),
        .input_ready  (input_ready)
    );

    always #5 clk = ~clk;

    // Reference model: scene, queue of pending requests, frames seen since entering scene
    int m_scene;
    int m_pend[$];
    int m_fis;
    int m_change;

    function automatic int m_lock();
        int l;
        l = 0;
        if (m_scene == 5 || m_scene == 6) begin
            l = LOCK - m_fis;
            if (l < 0) l = 0;
        end
        return l;
    endfunction

    function automatic int m_twinkle();
        if (m_scene == 0 || m_scene == 5 || m_scene == 6)
            return ((m_fis / TW) % 2 == 0) ? 1 : 0;
        return 0;
    endfunction

    function automatic int m_ready(input int lsel);
        if (m_pend.size() != 0) return 0;
        if (m_scene == 0) return 1;
        if (m_scene == 1 && lsel != 0) return 1;
        if ((m_scene == 5 || m_scene == 6) && m_lock() == 0) return 1;
        return 0;
    endfunction

    task automatic m_reset();
        m_scene  = 0;
        m_pend.delete();
        m_fis    = 0;
        m_change = 0;
    endtask

    task automatic m_step(input int t, input int ft, input int ls, input int w, input int l);
        int req;
        req = -1;
        if (m_pend.size() == 0) begin
            if (m_scene == 0 && t != 0) req = 1;
            else if (m_scene == 1 && t != 0 && ls != 0) req = ls + 1;
            else if (m_scene >= 2 && m_scene <= 4) begin
                if (l != 0) req = 6;
                else if (w != 0) req = 5;
            end else if ((m_scene == 5 || m_scene == 6) && t != 0 && m_lock() == 0) req = 1;
        end
        if (req >= 0) m_pend.push_back(req);
        m_change = 0;
        if (ft != 0) begin
            if (m_pend.size() != 0) begin
                m_scene  = m_pend.pop_front();
                m_fis    = 0;
                m_change = 1;
            end else begin
                m_fis++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic t, input logic ft, input logic [1:0] ls, input logic w, input logic l);
        @(negedge clk);
        tap        = t;
        frame_tick = ft;
        level_sel  = ls;
        game_win   = w;
        game_lose  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        tap        = 1'b0;
        frame_tick = 1'b0;
        level_sel  = 2'd0;
        game_win   = 1'b0;
        game_lose  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    typedef struct {
        logic       tap;
        logic       tick;
        logic [1:0] lsel;
        logic       win;
        logic       lose;
        logic [2:0] e_scene;
        logic       e_chg;
        logic       e_tw;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[16];

    initial begin
        //          tap tick lsel  win lose scene  chg tw rdy
        tbl[0]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0};

        rst        = 1'b1;
        tap        = 1'b0;
        frame_tick = 1'b0;
        level_sel  = 2'd0;
        game_win   = 1'b0;
        game_lose  = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_scene",   int'(scene), 0);
        chk("rst_change",  int'(scene_change), 0);
        chk("rst_twinkle", int'(twinkle), 1);
        chk("rst_ready",   int'(input_ready), 1);

        // Directed table: START -> MENU -> PLAY2 -> LOSE with lockout
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].tap, tbl[i].tick, tbl[i].lsel, tbl[i].win, tbl[i].lose);
            chk($sformatf("tbl%0d_scene", i),   int'(scene),        int'(tbl[i].e_scene));
            chk($sformatf("tbl%0d_change", i),  int'(scene_change), int'(tbl[i].e_chg));
            chk($sformatf("tbl%0d_twinkle", i), int'(twinkle),      int'(tbl[i].e_tw));
            chk($sformatf("tbl%0d_ready", i),   int'(input_ready),  int'(tbl[i].e_rdy));
        end

        // WIN screen: twinkle period and lockout boundary
        do_reset();
        step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("seqA_menu", int'(scene), 1);
        step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        chk("seqA_play1", int'(scene), 2);
        step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
        chk("seqA_win", int'(scene), 5);
        chk("seqA_win_chg", int'(scene_change), 1);
        chk("seqA_win_tw", int'(twinkle), 1);
        for (int k = 1; k <= 59; k++) begin
            step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
            chk($sformatf("seqA_tw_k%0d", k), int'(twinkle), (k < 30) ? 1 : 0);
            chk($sformatf("seqA_rdy_k%0d", k), int'(input_ready), 0);
        end
        step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        chk("seqA_locked_tap_rdy", int'(input_ready), 0);
        step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        chk("seqA_t60_scene", int'(scene), 5);
        chk("seqA_t60_rdy", int'(input_ready), 1);
        chk("seqA_t60_tw", int'(twinkle), 1);
        step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        chk("seqA_tap_pend_rdy", int'(input_ready), 0);
        chk("seqA_tap_pend_scene", int'(scene), 5);
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        chk("seqA_menu_back", int'(scene), 1);
        chk("seqA_menu_chg", int'(scene_change), 1);
        chk("seqA_menu_tw", int'(twinkle), 0);

        // Async reset while a request is pending in PLAY1
        do_reset();
        step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        chk("seqB_play1", int'(scene), 2);
        step(1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        chk("seqB_pend_scene", int'(scene), 2);
        @(negedge clk);
        tap = 1'b0; frame_tick = 1'b0; game_win = 1'b0; game_lose = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("seqB_rst_immediate", int'(scene), 0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        chk("seqB_no_commit_scene", int'(scene), 0);
        chk("seqB_no_commit_chg", int'(scene_change), 0);
        chk("seqB_ready", int'(input_ready), 1);

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 8000; i++) begin
            int r_tap, r_tick, r_ls, r_win, r_lose;
            r_tap  = ($urandom_range(0, 5) == 0) ? 1 : 0;
            r_tick = ($urandom_range(0, 4) == 0) ? 1 : 0;
            r_ls   = $urandom_range(0, 3);
            r_win  = ($urandom_range(0, 19) == 0) ? 1 : 0;
            r_lose = ($urandom_range(0, 19) == 0) ? 1 : 0;
            m_step(r_tap, r_tick, r_ls, r_win, r_lose);
            step(r_tap[0], r_tick[0], r_ls[1:0], r_win[0], r_lose[0]);
            chk("rnd_scene",   int'(scene),        m_scene);
            chk("rnd_change",  int'(scene_change), m_change);
            chk("rnd_twinkle", int'(twinkle),      m_twinkle());
            chk("rnd_ready",   int'(input_ready),  m_ready(r_ls));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
